// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the overflow rule used at completion.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Two's-complement overflow of X - Y: operand signs differ and result sign left X's sign.
  function automatic logic sub_ovf(input logic x_msb, input logic y_msb, input logic d_msb);
    return (x_msb != y_msb) && (d_msb != x_msb);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle of the bit-serial subtractor.
// The master issues START with operands; the slave answers with BUSY/DONE and results.
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
);

  logic             START;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             B_in;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DIFF;
  logic             B_out;
  logic             OVF;

  modport master (
    output START, X, Y, B_in,
    input  BUSY, DONE, DIFF, B_out, OVF
  );

  modport slave (
    input  START, X, Y, B_in,
    output BUSY, DONE, DIFF, B_out, OVF
  );

endinterface

// File: rtl/serial_sub_full_sub.sv
// Single-bit full subtractor cell: DIFF = X - Y - B_in, B_out = borrow out.
// Port naming mirrors the adder cells of the same library.
module full_sub (
  input  logic X,
  input  logic Y,
  input  logic B_in,
  output logic DIFF,
  output logic B_out
);

  assign DIFF  = X ^ Y ^ B_in;
  assign B_out = (~X & Y) | (~(X ^ Y) & B_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, one bit per clock LSB first through one full_sub cell.
// start/busy/done handshake; results are registered and held between completions.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  serial_sub_if.slave bus
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] xs_r;
  logic [WIDTH-1:0] ys_r;
  logic [WIDTH-1:0] res_r;
  logic             b_r;
  logic [CNT_W-1:0] cnt_r;
  logic             x_msb_r;
  logic             y_msb_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             b_out_r;
  logic             ovf_r;

  logic             d_s;
  logic             b_nxt_s;
  logic [WIDTH-1:0] res_nxt_s;

  full_sub u_cell (
    .X    (xs_r[0]),
    .Y    (ys_r[0]),
    .B_in (b_r),
    .DIFF (d_s),
    .B_out(b_nxt_s)
  );

  // Result shift register input: new difference bit enters at the MSB.
  always_comb begin
    res_nxt_s            = res_r >> 1;
    res_nxt_s[WIDTH-1]   = d_s;
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
      xs_r    <= {WIDTH{1'b0}};
      ys_r    <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      b_r     <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      x_msb_r <= 1'b0;
      y_msb_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      b_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.START) begin
            xs_r    <= bus.X;
            ys_r    <= bus.Y;
            b_r     <= bus.B_in;
            x_msb_r <= bus.X[WIDTH-1];
            y_msb_r <= bus.Y[WIDTH-1];
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          xs_r  <= xs_r >> 1;
          ys_r  <= ys_r >> 1;
          res_r <= res_nxt_s;
          b_r   <= b_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          // The last bit is still in flight, so results come from the next-state values.
          if (cnt_r == CNT_LAST) begin
            diff_r  <= res_nxt_s;
            b_out_r <= b_nxt_s;
            ovf_r   <= sub_ovf(x_msb_r, y_msb_r, d_s);
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY  = busy_r;
  assign bus.DONE  = done_r;
  assign bus.DIFF  = diff_r;
  assign bus.B_out = b_out_r;
  assign bus.OVF   = ovf_r;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub at WIDTH 1, 8 and 17 sharing one clock and reset.
// Expected results come from integer arithmetic on the operands.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(1))  if1  ();
  serial_sub_if #(.WIDTH(8))  if8  ();
  serial_sub_if #(.WIDTH(17)) if17 ();

  serial_sub #(.WIDTH(1))  u1  (.CLK(clk), .RST_N(rst_n), .bus(if1));
  serial_sub #(.WIDTH(8))  u8  (.CLK(clk), .RST_N(rst_n), .bus(if8));
  serial_sub #(.WIDTH(17)) u17 (.CLK(clk), .RST_N(rst_n), .bus(if17));

  int          sel = 8;
  logic        start_c = 1'b0;
  logic [63:0] x_c = 64'd0;
  logic [63:0] y_c = 64'd0;
  logic        b_c = 1'b0;

  assign if1.START  = (sel == 1)  ? start_c : 1'b0;
  assign if8.START  = (sel == 8)  ? start_c : 1'b0;
  assign if17.START = (sel == 17) ? start_c : 1'b0;
  assign if1.X  = x_c[0:0];
  assign if1.Y  = y_c[0:0];
  assign if8.X  = x_c[7:0];
  assign if8.Y  = y_c[7:0];
  assign if17.X = x_c[16:0];
  assign if17.Y = y_c[16:0];
  assign if1.B_in  = b_c;
  assign if8.B_in  = b_c;
  assign if17.B_in = b_c;

  logic        busy_c, done_c, bout_c, ovf_c;
  logic [63:0] diff_c;
  always_comb begin
    if (sel == 1) begin
      busy_c = if1.BUSY; done_c = if1.DONE; bout_c = if1.B_out; ovf_c = if1.OVF;
      diff_c = {63'd0, if1.DIFF};
    end else if (sel == 17) begin
      busy_c = if17.BUSY; done_c = if17.DONE; bout_c = if17.B_out; ovf_c = if17.OVF;
      diff_c = {47'd0, if17.DIFF};
    end else begin
      busy_c = if8.BUSY; done_c = if8.DONE; bout_c = if8.B_out; ovf_c = if8.OVF;
      diff_c = {56'd0, if8.DIFF};
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned borrow and signed range test.
  function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y,
                                input logic b, output logic [63:0] d, output logic bo,
                                output logic ov);
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint bi = b ? longint'(1) : longint'(0);
    longint sx = x[w-1] ? ux - full : ux;
    longint sy = y[w-1] ? uy - full : uy;
    longint s  = sx - sy - bi;
    d  = 64'(ux - uy - bi) & 64'(full - 1);
    bo = (ux < uy + bi);
    ov = (s < -half) || (s >= half);
  endfunction

  // One full operation from a negedge: accept, latency, results, single DONE pulse.
  task automatic do_op(input int w, input logic [63:0] x, input logic [63:0] y,
                       input logic b, input string tag);
    logic [63:0] ed;
    logic        eb, eo;
    int          e;
    model(w, x, y, b, ed, eb, eo);
    start_c = 1'b1; x_c = x; y_c = y; b_c = b;
    @(negedge clk);
    start_c = 1'b0;
    x_c = 64'($urandom); y_c = 64'($urandom); b_c = 1'($urandom);
    check({tag, "_busy"}, {63'd0, busy_c}, 64'd1);
    e = 0;
    while (!done_c && e < 100) begin
      @(negedge clk);
      e++;
    end
    check({tag, "_lat"}, 64'(e), 64'(w));
    check({tag, "_diff"}, diff_c, ed);
    check({tag, "_bout"}, {63'd0, bout_c}, {63'd0, eb});
    check({tag, "_ovf"}, {63'd0, ovf_c}, {63'd0, eo});
    @(negedge clk);
    check({tag, "_pulse"}, {63'd0, done_c}, 64'd0);
  endtask

  initial begin
    int          ndone, first, second, third;
    logic [63:0] dsave, msk, rx, ry;
    int          widths [3] = '{1, 8, 17};

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy_c}, 64'd0);
    check("rst_done", {63'd0, done_c}, 64'd0);
    check("rst_diff", diff_c, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sel = 8;
    do_op(8, 64'h5A, 64'h3C, 1'b0, "d5a3c");
    do_op(8, 64'h00, 64'h01, 1'b0, "d0001");
    do_op(8, 64'h10, 64'h0F, 1'b1, "d100f");
    do_op(8, 64'h80, 64'h01, 1'b0, "d8001");
    do_op(8, 64'h7F, 64'hFF, 1'b0, "d7fff");

    // START during BUSY must be ignored.
    start_c = 1'b1; x_c = 64'h5A; y_c = 64'h3C; b_c = 1'b0;
    @(negedge clk);
    start_c = 1'b0;
    repeat (2) @(negedge clk);
    start_c = 1'b1; x_c = 64'hFF; y_c = 64'h00;
    @(negedge clk);
    start_c = 1'b0;
    ndone = 0; dsave = 64'd0;
    for (int i = 0; i < 20; i++) begin
      if (done_c) begin ndone++; dsave = diff_c; end
      @(negedge clk);
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_diff", dsave, 64'h1E);
    check("ign_hold", diff_c, 64'h1E);

    // START held high: one completion every WIDTH+1 cycles.
    start_c = 1'b1; x_c = 64'h33; y_c = 64'h11; b_c = 1'b0;
    ndone = 0; first = 0; second = 0; third = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done_c) begin
        ndone++;
        if (ndone == 1) first = i;
        else if (ndone == 2) second = i;
        else third = i;
      end
    end
    start_c = 1'b0;
    check("held_ndone", 64'(ndone), 64'd3);
    check("held_gap1", 64'(second - first), 64'd9);
    check("held_gap2", 64'(third - second), 64'd9);
    check("held_diff", diff_c, 64'h22);
    repeat (12) @(negedge clk);

    // Reset in the middle of an operation aborts it silently.
    do_op(8, 64'hC3, 64'h42, 1'b1, "prerst");
    start_c = 1'b1; x_c = 64'h12; y_c = 64'h34; b_c = 1'b0;
    @(negedge clk);
    start_c = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy", {63'd0, busy_c}, 64'd0);
    check("mid_done", {63'd0, done_c}, 64'd0);
    check("mid_diff", diff_c, 64'd0);
    check("mid_bout", {63'd0, bout_c}, 64'd0);
    check("mid_ovf", {63'd0, ovf_c}, 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_c) ndone++;
    end
    check("mid_nodone", 64'(ndone), 64'd0);
    do_op(8, 64'h5A, 64'h3C, 1'b0, "postrst");

    // Randomised operations at each width.
    foreach (widths[k]) begin
      sel = widths[k];
      msk = (64'd1 << widths[k]) - 64'd1;
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        rx = {32'($urandom), 32'($urandom)} & msk;
        ry = {32'($urandom), 32'($urandom)} & msk;
        if (n % 10 == 0) ry = rx;
        do_op(widths[k], rx, ry, 1'($urandom), $sformatf("rnd_w%0d_%0d", widths[k], n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor, the inverse-direction companion to the adder cells: DIFF = X - Y - B_in.
- Processes one bit per clock, LSB first, through a single combinational full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake.
- Intended for area-constrained datapaths where a ripple array is too large.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..64).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
- START  input  1  request; sampled only when BUSY=0.
- X  input  WIDTH  minuend, sampled with accepted START.
- Y  input  WIDTH  subtrahend, sampled with accepted START.
- B_in  input  1  borrow-in, sampled with accepted START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse: results updated this cycle.
- DIFF  output  WIDTH  result X - Y - B_in mod 2^WIDTH.
- B_out  output  1  final borrow (1 = unsigned X < Y + B_in).
- OVF  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - state=IDLE; BUSY=0, DONE=0, DIFF=0, B_out=0, OVF=0.
  - Internal shift registers, counter and borrow FF are cleared.
  - Reset overrides START and aborts any operation in flight; the aborted result is never reported.
- States: IDLE, RUN.
- IDLE:
  - START=1 at an edge: latch X, Y into shift registers, B_in into the borrow FF, counter=0, go RUN, BUSY=1.
  - START=0: stay in IDLE.
- RUN, at each edge:
  - d = xs[0]^ys[0]^b.
  - b' = (~xs[0]&ys[0]) | (~(xs[0]^ys[0])&b).
  - Shift xs, ys right by 1; shift d into the MSB of the result shift register.
  - Increment the counter.
- Completion, at the edge where the counter reaches WIDTH-1 (the WIDTH-th RUN edge):
  - Load DIFF from the completed result register, B_out=b', and OVF=(Xmsb != Ymsb) && (DIFF msb != Xmsb). The X/Y MSBs are latched at accept.
  - DONE=1 for exactly one cycle; BUSY=0; return to IDLE.
- Latency: START accepted at edge k -> DONE, DIFF, B_out and OVF valid after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles minimum.
- Back-to-back: START held high during the DONE cycle is accepted at the next edge (state is IDLE).
- START while BUSY=1 is ignored: no queuing, no error.
- X, Y and B_in may change freely after the accept edge.
- DIFF, B_out and OVF hold their values between completions. They change only on a completion edge or on reset.
- WIDTH=1: a single RUN edge; the DONE cycle follows the accept edge by 1.
- Counter width is $clog2(WIDTH+1); no wrap-around is reachable.

Decomposition:
- Shared package holds the state enum (IDLE, RUN) and a default-width constant SUB_WIDTH_DEF=8.
- One sub-module, full_sub: combinational cell with ports X, Y, B_in, DIFF, B_out. It mirrors the existing adder cells and is instantiated once in the datapath.
- FSM, counter and shift registers stay in serial_sub.

Test Plan:
- WIDTH=8, X=0x5A, Y=0x3C, B_in=0, START 1 cycle -> BUSY for 8 cycles; DONE pulse 8 edges after accept; DIFF=0x1E, B_out=0, OVF=0.
- X=0x00, Y=0x01, B_in=0 -> DIFF=0xFF, B_out=1, OVF=0. Then X=0x10, Y=0x0F, B_in=1 -> DIFF=0x00, B_out=0.
- X=0x80, Y=0x01 -> DIFF=0x7F, B_out=0, OVF=1. Then X=0x7F, Y=0xFF -> DIFF=0x80, B_out=1, OVF=1.
- START pulsed with X=0x5A,Y=0x3C, then START with X=0xFF,Y=0x00 asserted at cycle 3 of BUSY -> second request ignored; DIFF=0x1E; exactly one DONE. Next, START held continuously -> operations complete every 9 cycles, DONE each time.
- RST_N=0 at cycle 4 of an operation -> next edge: BUSY=0, DONE=0, DIFF=0, B_out=0, OVF=0. No DONE follows. A fresh START then completes correctly.
- Randomised: 1000 operations at WIDTH=1, 8 and 17, each with random X/Y/B_in, checked against the golden model (X - Y - B_in) -> DIFF, B_out and OVF all match.
